// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result codes, immediate
// formats and the decode/execute pipeline bundle.
package riscv_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } immsrc_t;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       alusrc;
      logic [1:0] resultsrc;
      logic [2:0] alucontrol;
   } ctrl_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic        illegal;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } id_ex_t;

   function automatic logic [31:0] imm_ext(
      input logic [31:0] instr,
      input immsrc_t     sel
   );
      logic [31:0] imm;
      case (sel)
         IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25],
                       instr[11:8], 1'b0};
         IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20],
                       instr[30:21], 1'b0};
         default: imm = {{20{instr[31]}}, instr[31:20]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port,
// x0 hardwired to zero, same-cycle write-through to the readers.
module reg_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [4:0]  a3,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && a3 != 5'd0) begin
         regs[a3] <= wd;
      end
   end

   always_comb begin
      rd1 = regs[a1];
      rd2 = regs[a2];
      if (a1 == 5'd0)
         rd1 = '0;
      else if (we && a3 == a1)
         rd1 = wd;
      if (a2 == 5'd0)
         rd2 = '0;
      else if (we && a3 == a2)
         rd2 = wd;
   end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extend,
// and the decode/execute pipeline register.
module decode_cycle
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrd,
   input  logic [31:0] pcd,
   input  logic [31:0] pcplus4d,
   input  logic        flushe,
   input  logic        regwritew,
   input  logic [4:0]  rdw,
   input  logic [31:0] resultw,
   output logic [4:0]  rs1d,
   output logic [4:0]  rs2d,
   output logic        regwritee,
   output logic        memwritee,
   output logic        jumpe,
   output logic        branche,
   output logic        alusrce,
   output logic [1:0]  resultsrce,
   output logic [2:0]  alucontrole,
   output logic [31:0] rd1e,
   output logic [31:0] rd2e,
   output logic [31:0] immexte,
   output logic [31:0] pce,
   output logic [31:0] pcplus4e,
   output logic [4:0]  rs1e,
   output logic [4:0]  rs2e,
   output logic [4:0]  rde,
   output logic        illegale
);

   logic [6:0]  op;
   logic [2:0]  f3;
   logic        f7b5;
   logic [2:0]  alu_f;
   logic        f3_ok;
   ctrl_t       ctrl;
   logic        illegal;
   immsrc_t     immsrc;
   logic [31:0] rd1;
   logic [31:0] rd2;
   id_ex_t      de_d;
   id_ex_t      de_q;

   assign op   = instrd[6:0];
   assign f3   = instrd[14:12];
   assign f7b5 = instrd[30];
   assign rs1d = instrd[19:15];
   assign rs2d = instrd[24:20];

   reg_file u_rf (
      .clk (clk),
      .rst (rst),
      .a1  (rs1d),
      .a2  (rs2d),
      .a3  (rdw),
      .we  (regwritew),
      .wd  (resultw),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   // funct3 decode shared by R-type and I-ALU; only R-type can subtract
   always_comb begin
      alu_f = ALU_ADD;
      f3_ok = 1'b1;
      case (f3)
         3'b000: alu_f = (op == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
         3'b010: alu_f = ALU_SLT;
         3'b110: alu_f = ALU_OR;
         3'b111: alu_f = ALU_AND;
         default: f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      immsrc  = IMM_I;
      case (op)
         OP_R: begin
            ctrl.regwrite   = 1'b1;
            ctrl.alucontrol = alu_f;
            illegal         = !f3_ok;
         end
         OP_I: begin
            ctrl.regwrite   = 1'b1;
            ctrl.alusrc     = 1'b1;
            ctrl.alucontrol = alu_f;
            illegal         = !f3_ok;
         end
         OP_LW: begin
            ctrl.regwrite  = 1'b1;
            ctrl.alusrc    = 1'b1;
            ctrl.resultsrc = RES_MEM;
         end
         OP_SW: begin
            ctrl.memwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            immsrc        = IMM_S;
         end
         OP_BEQ: begin
            ctrl.branch     = 1'b1;
            ctrl.alucontrol = ALU_SUB;
            immsrc          = IMM_B;
         end
         OP_JAL: begin
            ctrl.regwrite  = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.resultsrc = RES_PC4;
            immsrc         = IMM_J;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) ctrl = '0;
   end

   always_comb begin
      de_d         = '0;
      de_d.ctrl    = ctrl;
      de_d.illegal = illegal;
      de_d.rd1     = rd1;
      de_d.rd2     = rd2;
      de_d.imm     = imm_ext(instrd, immsrc);
      de_d.pc      = pcd;
      de_d.pcplus4 = pcplus4d;
      de_d.rs1     = rs1d;
      de_d.rs2     = rs2d;
      de_d.rd      = instrd[11:7];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         de_q <= '0;
      else if (flushe)
         de_q <= '0;
      else
         de_q <= de_d;
   end

   assign regwritee   = de_q.ctrl.regwrite;
   assign memwritee   = de_q.ctrl.memwrite;
   assign jumpe       = de_q.ctrl.jump;
   assign branche     = de_q.ctrl.branch;
   assign alusrce     = de_q.ctrl.alusrc;
   assign resultsrce  = de_q.ctrl.resultsrc;
   assign alucontrole = de_q.ctrl.alucontrol;
   assign illegale    = de_q.illegal;
   assign rd1e        = de_q.rd1;
   assign rd2e        = de_q.rd2;
   assign immexte     = de_q.imm;
   assign pce         = de_q.pc;
   assign pcplus4e    = de_q.pcplus4;
   assign rs1e        = de_q.rs1;
   assign rs2e        = de_q.rs2;
   assign rde         = de_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: decode table plus reset, bypass,
// x0 and flush sequences.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instrd;
   logic [31:0] pcd;
   logic [31:0] pcplus4d;
   logic        flushe;
   logic        regwritew;
   logic [4:0]  rdw;
   logic [31:0] resultw;
   logic [4:0]  rs1d, rs2d;
   logic        regwritee, memwritee, jumpe, branche, alusrce;
   logic [1:0]  resultsrce;
   logic [2:0]  alucontrole;
   logic [31:0] rd1e, rd2e, immexte, pce, pcplus4e;
   logic [4:0]  rs1e, rs2e, rde;
   logic        illegale;
   logic [10:0] ctrl_e;

   int tests = 0;
   int fails = 0;
   logic [31:0] model [32];

   // {regwrite,memwrite,jump,branch,alusrc,resultsrc,alucontrol,illegal}
   assign ctrl_e = {regwritee, memwritee, jumpe, branche, alusrce,
                    resultsrce, alucontrole, illegale};

   always #5 clk = ~clk;

   decode_cycle dut (
      .clk         (clk),
      .rst         (rst),
      .instrd      (instrd),
      .pcd         (pcd),
      .pcplus4d    (pcplus4d),
      .flushe      (flushe),
      .regwritew   (regwritew),
      .rdw         (rdw),
      .resultw     (resultw),
      .rs1d        (rs1d),
      .rs2d        (rs2d),
      .regwritee   (regwritee),
      .memwritee   (memwritee),
      .jumpe       (jumpe),
      .branche     (branche),
      .alusrce     (alusrce),
      .resultsrce  (resultsrce),
      .alucontrole (alucontrole),
      .rd1e        (rd1e),
      .rd2e        (rd2e),
      .immexte     (immexte),
      .pce         (pce),
      .pcplus4e    (pcplus4e),
      .rs1e        (rs1e),
      .rs2e        (rs2e),
      .rde         (rde),
      .illegale    (illegale)
   );

   typedef struct {
      logic [31:0] instr;
      logic        flush;
      logic [10:0] ctrl;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        chk_imm;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ctrl"}, {21'd0, ctrl_e}, 32'd0);
      chk({tag, " rd1e"}, rd1e, 32'd0);
      chk({tag, " rd2e"}, rd2e, 32'd0);
      chk({tag, " imm"}, immexte, 32'd0);
      chk({tag, " pc"}, pce ^ pcplus4e, 32'd0);
      chk({tag, " pc4"}, pcplus4e, 32'd0);
      chk({tag, " regs"}, {17'd0, rs1e, rs2e, rde}, 32'd0);
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] v);
      regwritew = 1'b1;
      rdw       = r;
      resultw   = v;
      instrd    = 32'h0;
      step();
      regwritew = 1'b0;
      if (r != 5'd0) model[r] = v;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      vecs[0]  = '{32'hFFD00293, 1'b0, 11'b10001_00_000_0, 5'd5,  5'd0, 5'd29, 32'hFFFFFFFD, 1'b1};
      vecs[1]  = '{32'hFE208CE3, 1'b0, 11'b00010_00_001_0, 5'd25, 5'd1, 5'd2,  32'hFFFFFFF8, 1'b1};
      vecs[2]  = '{32'h001000EF, 1'b0, 11'b10100_10_000_0, 5'd1,  5'd0, 5'd1,  32'h00000800, 1'b1};
      vecs[3]  = '{32'h00322623, 1'b0, 11'b01001_00_000_0, 5'd12, 5'd4, 5'd3,  32'h0000000C, 1'b1};
      vecs[4]  = '{32'h00412303, 1'b0, 11'b10001_01_000_0, 5'd6,  5'd2, 5'd4,  32'h00000004, 1'b1};
      vecs[5]  = '{32'h402084B3, 1'b0, 11'b10000_00_001_0, 5'd9,  5'd1, 5'd2,  32'h0, 1'b0};
      vecs[6]  = '{32'h0020F533, 1'b0, 11'b10000_00_010_0, 5'd10, 5'd1, 5'd2,  32'h0, 1'b0};
      vecs[7]  = '{32'h0020E5B3, 1'b0, 11'b10000_00_011_0, 5'd11, 5'd1, 5'd2,  32'h0, 1'b0};
      vecs[8]  = '{32'h0020A633, 1'b0, 11'b10000_00_101_0, 5'd12, 5'd1, 5'd2,  32'h0, 1'b0};
      vecs[9]  = '{32'h00512193, 1'b0, 11'b10001_00_101_0, 5'd3,  5'd2, 5'd5,  32'h00000005, 1'b1};
      vecs[10] = '{32'h0020C6B3, 1'b0, 11'b00000_00_000_1, 5'd13, 5'd1, 5'd2,  32'h0, 1'b0};
      vecs[11] = '{32'h0000007F, 1'b0, 11'b00000_00_000_1, 5'd0,  5'd0, 5'd0,  32'h0, 1'b0};
      vecs[12] = '{32'h00000000, 1'b0, 11'b00000_00_000_1, 5'd0,  5'd0, 5'd0,  32'h0, 1'b0};
      vecs[13] = '{32'hFFF0E393, 1'b0, 11'b10001_00_011_0, 5'd7,  5'd1, 5'd31, 32'hFFFFFFFF, 1'b1};
      vecs[14] = '{32'hFFF0F393, 1'b0, 11'b10001_00_010_0, 5'd7,  5'd1, 5'd31, 32'hFFFFFFFF, 1'b1};
      vecs[15] = '{32'h00109393, 1'b0, 11'b00000_00_000_1, 5'd7,  5'd1, 5'd1,  32'h0, 1'b0};
      vecs[16] = '{32'h0020F533, 1'b1, 11'b10000_00_010_0, 5'd10, 5'd1, 5'd2,  32'h0, 1'b0};

      // reset with garbage on every input, including a write attempt
      rst       = 1'b1;
      instrd    = 32'h0020F533;
      pcd       = 32'hCAFEF00D;
      pcplus4d  = 32'hCAFEF011;
      flushe    = 1'b0;
      regwritew = 1'b1;
      rdw       = 5'd5;
      resultw   = 32'hBAD0BAD0;
      #2 rst = 1'b0;
      #2 chk_zero("async reset");
      step();
      step();
      chk_zero("reset hold");
      regwritew = 1'b0;
      instrd    = 32'h0;
      pcd       = 32'h0;
      pcplus4d  = 32'h0;
      rst       = 1'b1;
      step();
      chk("first capture illegal", {21'd0, ctrl_e}, 32'd1);

      for (int r = 1; r < 32; r++) begin
         instrd = {7'd0, 5'(r), 5'(r), 3'b000, 5'd1, 7'b0110011};
         step();
         chk($sformatf("reset x%0d", r), rd1e | rd2e, 32'd0);
      end

      wb(5'd1, 32'h11111111);
      wb(5'd2, 32'h22222222);
      wb(5'd3, 32'h33333333);
      wb(5'd4, 32'h44444444);

      for (int i = 0; i < 17; i++) begin
         instrd   = vecs[i].instr;
         flushe   = vecs[i].flush;
         pcd      = 32'h1000 + 32'(i * 4);
         pcplus4d = 32'h1004 + 32'(i * 4);
         #1;
         chk($sformatf("v%0d rs1d", i), {27'd0, rs1d}, {27'd0, vecs[i].rs1});
         chk($sformatf("v%0d rs2d", i), {27'd0, rs2d}, {27'd0, vecs[i].rs2});
         step();
         if (vecs[i].flush) begin
            chk_zero($sformatf("v%0d flush", i));
         end else begin
            chk($sformatf("v%0d ctrl", i), {21'd0, ctrl_e}, {21'd0, vecs[i].ctrl});
            chk($sformatf("v%0d rde", i), {27'd0, rde}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d rs1e", i), {27'd0, rs1e}, {27'd0, vecs[i].rs1});
            chk($sformatf("v%0d rs2e", i), {27'd0, rs2e}, {27'd0, vecs[i].rs2});
            chk($sformatf("v%0d rd1e", i), rd1e, model[vecs[i].rs1]);
            chk($sformatf("v%0d rd2e", i), rd2e, model[vecs[i].rs2]);
            chk($sformatf("v%0d pce", i), pce, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d pc4e", i), pcplus4e, 32'h1004 + 32'(i * 4));
            if (vecs[i].chk_imm)
               chk($sformatf("v%0d imm", i), immexte, vecs[i].imm);
         end
         flushe = 1'b0;
      end

      // same-cycle writeback bypass, then the stored value
      regwritew = 1'b1;
      rdw       = 5'd7;
      resultw   = 32'hDEADBEEF;
      instrd    = 32'h00738433;
      step();
      regwritew = 1'b0;
      chk("bypass rd1e", rd1e, 32'hDEADBEEF);
      chk("bypass rd2e", rd2e, 32'hDEADBEEF);
      chk("bypass rde", {27'd0, rde}, 32'd8);
      step();
      chk("stored x7", rd1e, 32'hDEADBEEF);

      // x0 write ignored, both same-cycle and afterwards
      regwritew = 1'b1;
      rdw       = 5'd0;
      resultw   = 32'h12345678;
      instrd    = 32'h00000433;
      step();
      regwritew = 1'b0;
      chk("x0 bypass", rd1e | rd2e, 32'd0);
      step();
      chk("x0 read", rd1e | rd2e, 32'd0);

      // flush together with an illegal opcode
      flushe = 1'b1;
      instrd = 32'h0000007F;
      pcd    = 32'h2000;
      step();
      flushe = 1'b0;
      chk_zero("flush+illegal");

      // write still lands while flushing
      flushe    = 1'b1;
      regwritew = 1'b1;
      rdw       = 5'd9;
      resultw   = 32'h0BADCAFE;
      step();
      flushe    = 1'b0;
      regwritew = 1'b0;
      instrd    = 32'h00048033;
      step();
      chk("write under flush", rd1e, 32'h0BADCAFE);

      // mid-stream asynchronous reset clears E and the register file
      instrd = 32'h00738433;
      pcd    = 32'h3000;
      step();
      chk("pre-reset rd1e", rd1e, 32'hDEADBEEF);
      #2 rst = 1'b0;
      #1 chk_zero("mid reset");
      step();
      rst = 1'b1;
      step();
      chk("x7 after reset", rd1e | rd2e, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second pipeline stage of the five-stage RV32I core. Consumes the fetch-stage outputs (instruction, PC, PC+4), decodes control, reads the 32×32 register file, and extends the immediate. Registers everything into the decode/execute pipeline register that feeds the execute stage. Also owns the register-file write port, driven from writeback.

## Interface
Parameters: none. XLEN is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instrd  in  32  instruction from the fetch/decode register
- pcd  in  32  PC of that instruction
- pcplus4d  in  32  PC+4 of that instruction
- flushe  in  1  load a bubble into the D/E register this cycle (hazard unit or taken branch)
- regwritew  in  1  writeback register-file write enable
- rdw  in  5  writeback destination register
- resultw  in  32  writeback data
- rs1d, rs2d  out  5  combinational source indices, for the hazard unit
- regwritee, memwritee, jumpe, branche, alusrce  out  1  registered control bits
- resultsrce  out  2  00 = ALU, 01 = memory, 10 = PC+4
- alucontrole  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- rd1e, rd2e, immexte, pce, pcplus4e  out  32  registered data
- rs1e, rs2e, rde  out  5  registered register indices
- illegale  out  1  registered: the opcode is not supported

## Operation
- Supported opcodes:
  - 0110011 R-type: add, sub, and, or, slt.
  - 0010011 I-ALU: addi, andi, ori, slti.
  - 0000011 lw.
  - 0100011 sw.
  - 1100011 beq.
  - 1101111 jal.
- Immediate select:
  - I-format: {20×instr[31], instr[31:20]}.
  - S-format: instr[31:25], instr[11:7].
  - B-format: instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - J-format: instr[31], instr[19:12], instr[20], instr[30:21], 0.
  - All immediates are sign-extended from instr[31].
- ALU decode:
  - lw, sw, jal → add.
  - beq → sub.
  - R/I-ALU by funct3: 000 gives add, or sub when the op is R-type and funct7[5]=1. 010 gives slt, 110 gives or, 111 gives and. Any other funct3 is illegal.
- Illegal instruction:
  - Applies to an unknown opcode or an unsupported funct3.
  - All control outputs are forced to 0 (bubble).
  - illegale=1. Data fields still pass through.
  - instrd = 0x00000000 is illegal.
- Register file:
  - x0 reads 0, and writes to x0 are ignored.
  - Reads are combinational.
  - Writes happen at posedge clk when regwritew=1.
  - Write-through bypass: if regwritew=1, rdw≠0 and rdw equals rs1d or rs2d, the read returns resultw in the same cycle.
- flushe=1:
  - All control outputs (regwritee, memwritee, jumpe, branche, alusrce, resultsrce, alucontrole) and illegale load 0.
  - rde, rs1e and rs2e load 0.
  - The data fields load 0.
- The register-file write is independent of flushe.

## Timing
- Decode-to-execute latency is 1 cycle. Instruction N present on instrd in cycle t appears on the E outputs after the posedge ending cycle t.
- Reset (rst=0), asynchronous:
  - Every E output goes to 0 immediately.
  - All 32 registers clear to 0.
- The E register holds its value only through reset. There is no stall input; stalls are absorbed upstream by the fetch register.
- Simultaneous events:
  - Writeback to register r in the same cycle decode reads r returns the new value (bypass).
  - flushe and an illegal instruction together produce an all-zero E register.
- Reset released mid-stream: the first posedge after rst rises captures whatever is on instrd. Upstream also presents 0 during reset, so the first capture is an illegal bubble (illegale=1) unless the fetch register has already advanced.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL);
  - ALU codes;
  - resultsrc codes;
  - immsrc encodings.
- One sub-module, reg_file: 2 read ports, 1 write port, x0 hardwired, bypass logic.
- Control and immediate decode stay inline.

## Test plan
- Reset: hold rst=0 and preload garbage on the inputs → all E outputs are 0, and reading x1..x31 returns 0 after release.
- addi x5,x0,-3 (0xFFD00293) → immexte=0xFFFFFFFD, alusrce=1, regwritee=1, alucontrole=000, rde=5, resultsrce=00.
- Writeback rdw=7, resultw=0xDEADBEEF, regwritew=1 in the same cycle as add x8,x7,x7 → rd1e = rd2e = 0xDEADBEEF. A write to x0 followed by a read of x0 → 0.
- beq x1,x2,-8 (0xFE208CE3) → branche=1, alucontrole=001, immexte=0xFFFFFFF8. jal x1,+2048 → jumpe=1, resultsrce=10, immexte=0x00000800.
- sw x3,12(x4) (0x00322623) → memwritee=1, regwritee=0, immexte=0x0000000C. lw then follows → resultsrce=01.
- flushe=1 with a valid R-type present → all control outputs 0. Opcode 0x7F → illegale=1 with all control outputs 0.
